// File: rtl/cgra_pkg.sv
// Shared constants for the CGRA tile: sizes, instruction field layout, opcodes
// and the fixed configuration-memory program.
package cgra_pkg;

    localparam int unsigned DW       = 16;
    localparam int unsigned CM_DEPTH = 64;
    localparam int unsigned AW       = 6;
    localparam int unsigned NREG     = 4;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_W    = 2;
    localparam int unsigned IMM_W    = 6;
    localparam int unsigned SHAMT_W  = 4;

    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned DST_LSB  = 10;
    localparam int unsigned SRCA_LSB = 8;
    localparam int unsigned SRCB_LSB = 6;
    localparam int unsigned IMM_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDI = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
    localparam logic [OPC_W-1:0] OP_AND = 4'd4;
    localparam logic [OPC_W-1:0] OP_OR  = 4'd5;
    localparam logic [OPC_W-1:0] OP_XOR = 4'd6;
    localparam logic [OPC_W-1:0] OP_SHL = 4'd7;
    localparam logic [OPC_W-1:0] OP_SHR = 4'd8;
    localparam logic [OPC_W-1:0] OP_MOV = 4'd9;

    // Program image: two loads, an add/sub pair, then an accumulate run of R0 += R1.
    function automatic logic [DW-1:0] cm_word(input int unsigned addr);
        if (addr == 0)                return 16'h1005;
        if (addr == 1)                return 16'h1403;
        if (addr == 2)                return 16'h2840;
        if (addr == 3)                return 16'h3C40;
        if (addr >= 4 && addr <= 21)  return 16'h2040;
        return 16'h0000;
    endfunction

endpackage

// File: rtl/cgra_alu.sv
// Combinational datapath for one instruction; we_c is low for NOP-class opcodes.
module cgra_alu
    import cgra_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [IMM_W-1:0] imm6,
    output logic [DW-1:0]    value_c,
    output logic             we_c
);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = imm6[SHAMT_W-1:0];

    always_comb begin
        value_c = '0;
        we_c    = 1'b1;
        case (opcode)
            OP_LDI:  value_c = DW'(imm6);
            OP_ADD:  value_c = a + b;
            OP_SUB:  value_c = a - b;
            OP_AND:  value_c = a & b;
            OP_OR:   value_c = a | b;
            OP_XOR:  value_c = a ^ b;
            OP_SHL:  value_c = a << shamt;
            OP_SHR:  value_c = a >> shamt;
            OP_MOV:  value_c = a;
            OP_NOP:  we_c    = 1'b0;
            default: we_c    = 1'b0;
        endcase
    end

endmodule

// File: rtl/cgra_top.sv
// Single-tile CGRA: addressed fetch from a fixed config ROM, then one execute
// stage against a 4-entry register file. No program counter; the host issues addresses.
module cgra_top #(
    parameter int unsigned CM_DEPTH = cgra_pkg::CM_DEPTH,
    parameter int unsigned DW       = cgra_pkg::DW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_cm_en,
    input  logic [$clog2(CM_DEPTH)-1:0] cm_addr,
    output logic [DW-1:0]               data_out,
    output logic [DW-1:0]               result,
    output logic                        result_valid
);
    import cgra_pkg::*;

    logic [DW-1:0] cm [CM_DEPTH];
    logic [DW-1:0] cfg_q;
    logic          fetch_valid;
    logic [DW-1:0] rf [NREG];

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic [IMM_W-1:0] imm6;
    logic [DW-1:0]    alu_value;
    logic             alu_we;

    for (genvar i = 0; i < CM_DEPTH; i++) begin : g_cm
        assign cm[i] = cm_word(i);
    end

    assign opcode = cfg_q[OPC_LSB  +: OPC_W];
    assign dst    = cfg_q[DST_LSB  +: REG_W];
    assign src_a  = cfg_q[SRCA_LSB +: REG_W];
    assign src_b  = cfg_q[SRCB_LSB +: REG_W];
    assign imm6   = cfg_q[IMM_LSB  +: IMM_W];

    cgra_alu u_alu (
        .opcode  (opcode),
        .a       (rf[src_a]),
        .b       (rf[src_b]),
        .imm6    (imm6),
        .value_c (alu_value),
        .we_c    (alu_we)
    );

    // Fetch and execute share one edge; execute reads registers before this edge's write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q        <= '0;
            fetch_valid  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (rd_cm_en) cfg_q <= cm[cm_addr];
            fetch_valid  <= rd_cm_en;
            result_valid <= fetch_valid & alu_we;
            if (fetch_valid && alu_we) begin
                rf[dst] <= alu_value;
                result  <= alu_value;
            end
        end
    end

    assign data_out = cfg_q;

endmodule

// File: tb/tb_cgra_top.sv
// Directed bench for cgra_top with a reference model feeding an in-order
// expectation queue; each entry is checked the cycle after its issue's fetch.
module tb_cgra_top;

    logic        clk;
    logic        reset;
    logic        rd_cm_en;
    logic [5:0]  cm_addr;
    logic [15:0] data_out;
    logic [15:0] result;
    logic        result_valid;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;

    typedef struct {
        logic        v;
        logic [15:0] r;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_r [4];
    logic [15:0] m_result;
    logic [15:0] exp_data;

    cgra_top dut (
        .clk          (clk),
        .reset        (reset),
        .rd_cm_en     (rd_cm_en),
        .cm_addr      (cm_addr),
        .data_out     (data_out),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] ref_cm(input int a);
        if (a == 0) return 16'h1005;
        if (a == 1) return 16'h1403;
        if (a == 2) return 16'h2840;
        if (a == 3) return 16'h3C40;
        if (a >= 4 && a <= 21) return 16'h2040;
        return 16'h0000;
    endfunction

    // Reference execution of one instruction word against the model registers.
    task automatic m_exec(input logic [15:0] w, output exp_t e);
        logic [3:0]  op;
        logic [15:0] a, b, v;
        logic        we;
        op = w[15:12];
        a  = m_r[w[9:8]];
        b  = m_r[w[7:6]];
        we = 1'b1;
        v  = 16'h0;
        if      (op == 4'd1) v = {10'b0, w[5:0]};
        else if (op == 4'd2) v = 16'(a + b);
        else if (op == 4'd3) v = 16'(a - b);
        else if (op == 4'd4) v = a & b;
        else if (op == 4'd5) v = a | b;
        else if (op == 4'd6) v = a ^ b;
        else if (op == 4'd7) v = 16'(a << w[3:0]);
        else if (op == 4'd8) v = a >> w[3:0];
        else if (op == 4'd9) v = a;
        else we = 1'b0;
        if (we) begin
            m_r[w[11:10]] = v;
            m_result      = v;
        end
        e.v = we;
        e.r = m_result;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
        m_result = 16'h0;
        exp_data = 16'h0;
        q.delete();
        q.push_back('{v: 1'b0, r: 16'h0});
    endtask

    task automatic cycle(input logic en, input logic [5:0] addr);
        exp_t e;
        rd_cm_en = en;
        cm_addr  = addr;
        if (en) begin
            exp_data = ref_cm(int'(addr));
            m_exec(exp_data, e);
        end else begin
            e.v = 1'b0;
            e.r = m_result;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("data_out", data_out, exp_data);
        if (q.size() > 1) begin
            e = q.pop_front();
            chk("result_valid", result_valid, e.v);
            chk("result", result, e.r);
        end
        run_len = result_valid ? run_len + 1 : 0;
    endtask

    initial begin
        reset    = 1'b1;
        rd_cm_en = 1'b0;
        cm_addr  = 6'd0;
        @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 16'h0);
        chk("rst_result", result, 16'h0);
        chk("rst_result_valid", result_valid, 1'b0);
        reset = 1'b0;
        m_reset();

        // Four-instruction warm-up
        for (int a = 0; a < 4; a++) cycle(1'b1, 6'(a));
        cycle(1'b0, 6'd0);
        chk("r2_after_add", dut.rf[2], 16'd8);
        chk("r3_after_sub", dut.rf[3], 16'd2);
        chk("result_after_sub", result, 16'd2);

        // Full program run
        for (int a = 0; a < 22; a++) cycle(1'b1, 6'(a));
        cycle(1'b0, 6'd0);
        chk("run_valid_len", run_len, 32'd22);
        chk("run_final_result", result, 16'd59);
        cycle(1'b0, 6'd0);

        cycle(1'b1, 6'd0);
        cycle(1'b0, 6'd0);
        chk("reissue_result", result, 16'd5);
        chk("reissue_r1", dut.rf[1], 16'd3);

        // Idle with wandering address
        for (int i = 0; i < 5; i++) cycle(1'b0, 6'($urandom_range(63)));
        for (int i = 0; i < 4; i++) chk("idle_regs", dut.rf[i], m_r[i]);
        chk("idle_data_out", data_out, 16'h1005);

        cycle(1'b1, 6'd40);
        cycle(1'b0, 6'd0);
        chk("nop_data_out", data_out, 16'h0000);
        chk("nop_result_hold", result, 16'd5);

        // Reset with LDI R1 in flight
        cycle(1'b1, 6'd1);
        reset = 1'b1;
        #1;
        chk("async_data_out", data_out, 16'h0);
        chk("async_result", result, 16'h0);
        chk("async_result_valid", result_valid, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rd_cm_en = 1'b0;
        m_reset();
        cycle(1'b0, 6'd1);
        chk("discard_r1", dut.rf[1], 16'h0);
        cycle(1'b1, 6'd2);
        cycle(1'b0, 6'd0);
        chk("post_rst_result", result, 16'h0);
        chk("post_rst_r0", dut.rf[0], 16'h0);
        chk("post_rst_r1", dut.rf[1], 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
